// File: rtl/trace_pkg.sv
// Shared types for the ap_ctrl handshake tracer: record layout, error bit
// positions and the recorder state machine encoding.
package trace_pkg;

   localparam int ID_W     = 8;
   localparam int TS_W_DEF = 32;

   localparam int ERR_OVERFLOW = 0;
   localparam int ERR_ORPHAN   = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_FLUSH
   } traceState_t;

   // Record layout at the default timestamp width, module ID in the MSBs.
   typedef struct packed {
      logic [ID_W-1:0]     id;
      logic [TS_W_DEF-1:0] startTs;
      logic [TS_W_DEF-1:0] doneTs;
      logic [TS_W_DEF-1:0] latency;
   } traceRec_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is on rdata whenever
// count is nonzero, and a push into a full FIFO succeeds if a pop happens alongside.
module trace_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic             doPush;
   logic             doPop;

   assign doPop  = pop && (count != '0);
   assign doPush = push && ((count != (AW+1)'(DEPTH)) || doPop);
   assign rdata  = mem[rdPtr];

   always_ff @(posedge clock) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
      end
   end

   // Storage is deliberately left unreset; only valid entries are ever observed.
   always_ff @(posedge clock) begin
      if (doPush) mem[wrPtr] <= wdata;
   end

endmodule

// File: rtl/ap_ctrl_trace_recorder.sv
// Watches one HLS block's ap_ctrl_hs handshake, timestamps accepted starts and
// emits {ID, start_ts, done_ts, latency} records on a valid/ready stream.
module ap_ctrl_trace_recorder
   import trace_pkg::*;
#(
   parameter logic [ID_W-1:0] ID = 8'h00,
   parameter int TS_W     = 32,
   parameter int SQ_DEPTH = 4,
   parameter int RQ_DEPTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   ap_start,
   input  logic                   ap_ready,
   input  logic                   ap_done,
   input  logic                   ap_continue,
   input  logic                   finish,
   output logic                   rec_valid,
   input  logic                   rec_ready,
   output logic [ID_W+3*TS_W-1:0] rec_data,
   output logic [15:0]            drop_cnt,
   output logic [1:0]             err,
   output logic                   finish_done
);

   localparam int REC_W = ID_W + 3*TS_W;
   localparam int SQ_CW = $clog2(SQ_DEPTH) + 1;
   localparam int RQ_CW = $clog2(RQ_DEPTH) + 1;

   traceState_t      state;
   logic [TS_W-1:0]  ts;
   logic [TS_W-1:0]  sqHead;
   logic [SQ_CW-1:0] sqCount;
   logic [REC_W-1:0] rqHead;
   logic [RQ_CW-1:0] rqCount;
   logic [TS_W-1:0]  recStart;
   logic [REC_W-1:0] recWord;
   logic sqEmpty, sqFull, rqEmpty, rqFull;
   logic active, accept, complete;
   logic sqPush, sqPop, sqNextEmpty;
   logic recMake, rqPush, recDrop, overflow, orphan;

   assign sqEmpty = (sqCount == '0);
   assign sqFull  = (sqCount == SQ_CW'(SQ_DEPTH));
   assign rqEmpty = (rqCount == '0);
   assign rqFull  = (rqCount == RQ_CW'(RQ_DEPTH));

   // Events are ignored from the cycle finish is seen onwards.
   assign active   = (state != ST_FLUSH) && !finish;
   assign accept   = active && ap_start && ap_ready;
   assign complete = active && ap_done && ap_continue;

   // An accept landing on an empty queue in the same cycle as a completion
   // bypasses the queue and pairs with the completion directly.
   assign sqPop    = complete && !sqEmpty;
   assign sqPush   = accept && !(complete && sqEmpty) && (!sqFull || sqPop);
   assign overflow = accept && sqFull && !sqPop;
   assign orphan   = complete && sqEmpty && !accept;
   assign recMake  = complete && (!sqEmpty || accept);
   assign recStart = sqEmpty ? ts : sqHead;
   assign recWord  = {ID, recStart, ts, ts - recStart};

   assign sqNextEmpty = (sqEmpty && !sqPush) ||
                        ((sqCount == SQ_CW'(1)) && sqPop && !sqPush);

   assign rqPush    = recMake && (!rqFull || (rec_valid && rec_ready));
   assign recDrop   = recMake && !rqPush;
   assign rec_valid = !rqEmpty;
   assign rec_data  = rqEmpty ? '0 : rqHead;

   trace_fifo #(.WIDTH(TS_W), .DEPTH(SQ_DEPTH)) startQueue (
      .clock (clock),
      .reset (reset),
      .push  (sqPush),
      .wdata (ts),
      .pop   (sqPop),
      .rdata (sqHead),
      .count (sqCount)
   );

   trace_fifo #(.WIDTH(REC_W), .DEPTH(RQ_DEPTH)) recordQueue (
      .clock (clock),
      .reset (reset),
      .push  (rqPush),
      .wdata (recWord),
      .pop   (rec_ready),
      .rdata (rqHead),
      .count (rqCount)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         ts       <= '0;
         drop_cnt <= '0;
         err      <= '0;
      end else begin
         ts <= ts + 1'b1;
         if (recDrop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
         if (overflow) err[ERR_OVERFLOW] <= 1'b1;
         if (orphan)   err[ERR_ORPHAN]   <= 1'b1;
      end
   end

   // FLUSH is terminal until reset; finish_done follows the record FIFO draining.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= ST_IDLE;
         finish_done <= 1'b0;
      end else if (finish || (state == ST_FLUSH)) begin
         state <= ST_FLUSH;
         if (rqEmpty) finish_done <= 1'b1;
      end else begin
         state <= sqNextEmpty ? ST_IDLE : ST_BUSY;
      end
   end

endmodule

// File: tb/tb_ap_ctrl_trace_recorder.sv
// Directed bench for ap_ctrl_trace_recorder: a per-cycle vector table for the
// pipelined case plus hand-written sequences for the multi-cycle corners.
module tb_ap_ctrl_trace_recorder;
   import trace_pkg::*;

   typedef struct {
      bit          start;
      bit          done;
      bit          expValid;
      int          expStart;
      int          expDone;
      logic [1:0]  expErr;
   } vector_t;

   logic         clock = 1'b0;
   logic         reset, ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready;
   logic         rec_valid, finish_done;
   logic [103:0] rec_data;
   logic [15:0]  drop_cnt;
   logic [1:0]   err;
   logic         wrapValid, wrapFinishDone;
   logic [19:0]  wrapData;
   logic [15:0]  wrapDrop;
   logic [1:0]   wrapErr;

   int testsRun    = 0;
   int testsFailed = 0;
   int cyc         = 0;
   vector_t vec [16];

   always #5 clock = ~clock;

   ap_ctrl_trace_recorder #(.ID(8'h3C), .TS_W(32), .SQ_DEPTH(4), .RQ_DEPTH(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .ap_start    (ap_start),
      .ap_ready    (ap_ready),
      .ap_done     (ap_done),
      .ap_continue (ap_continue),
      .finish      (finish),
      .rec_valid   (rec_valid),
      .rec_ready   (rec_ready),
      .rec_data    (rec_data),
      .drop_cnt    (drop_cnt),
      .err         (err),
      .finish_done (finish_done)
   );

   // Narrow-timestamp copy so counter wrap is reachable in a few cycles.
   ap_ctrl_trace_recorder #(.ID(8'hA5), .TS_W(4), .SQ_DEPTH(4), .RQ_DEPTH(8)) wrapDut (
      .clock       (clock),
      .reset       (reset),
      .ap_start    (ap_start),
      .ap_ready    (ap_ready),
      .ap_done     (ap_done),
      .ap_continue (ap_continue),
      .finish      (finish),
      .rec_valid   (wrapValid),
      .rec_ready   (rec_ready),
      .rec_data    (wrapData),
      .drop_cnt    (wrapDrop),
      .err         (wrapErr),
      .finish_done (wrapFinishDone)
   );

   function automatic traceRec_t expRec(int s, int d);
      traceRec_t r;
      r.id      = 8'h3C;
      r.startTs = 32'(s);
      r.doneTs  = 32'(d);
      r.latency = 32'(d) - 32'(s);
      return r;
   endfunction

   task automatic applyStimulus(input bit s, input bit d, input bit r);
      ap_start  = s;
      ap_ready  = s;
      ap_done   = d;
      rec_ready = r;
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic doReset();
      reset = 1'b1;
      finish = 1'b0;
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      reset = 1'b0;
      cyc = 0;
   endtask

   initial begin
      reset = 1'b1; ap_start = 0; ap_ready = 0; ap_done = 0;
      ap_continue = 1'b1; finish = 0; rec_ready = 0;

      // Pipelined overlap: expectations in entry i are the outputs one cycle later.
      foreach (vec[i]) vec[i] = '{start: 0, done: 0, expValid: 0, expStart: 0,
                                  expDone: 0, expErr: (i >= 6) ? 2'b01 : 2'b00};
      for (int i = 2; i <= 6; i++) vec[i].start = 1;
      for (int i = 10; i <= 13; i++) begin
         vec[i].done     = 1;
         vec[i].expValid = 1;
         vec[i].expStart = i - 8;
         vec[i].expDone  = i;
      end

      // Reset values.
      doReset();
      checkOutput("reset_valid", rec_valid, 0);
      checkOutput("reset_data", rec_data, 0);
      checkOutput("reset_drop", drop_cnt, 0);
      checkOutput("reset_err", err, 0);
      checkOutput("reset_finish_done", finish_done, 0);

      // Single transaction: accept at ts 5, done at ts 17.
      while (cyc < 19) begin
         applyStimulus(cyc == 5, cyc == 17, 0);
         if (cyc == 17) checkOutput("single_no_early_valid", rec_valid, 0);
         if (cyc == 18) begin
            checkOutput("single_valid", rec_valid, 1);
            checkOutput("single_data", rec_data, expRec(5, 17));
         end
      end
      checkOutput("single_data_held", rec_data, expRec(5, 17));
      checkOutput("single_err", err, 0);

      // Table-driven pipelined overlap with a start overflow.
      doReset();
      for (int i = 0; i < 16; i++) begin
         applyStimulus(vec[i].start, vec[i].done, 1);
         checkOutput($sformatf("pipe_valid_%0d", i), rec_valid, vec[i].expValid);
         if (vec[i].expValid)
            checkOutput($sformatf("pipe_data_%0d", i), rec_data,
                        expRec(vec[i].expStart, vec[i].expDone));
         checkOutput($sformatf("pipe_err_%0d", i), err, vec[i].expErr);
      end

      // Orphan done, then same-cycle accept/complete on an empty queue.
      doReset();
      while (cyc < 12) begin
         applyStimulus(cyc == 3 || cyc == 6, cyc == 1 || cyc == 3 || cyc == 9, 1);
         if (cyc == 2) begin
            checkOutput("orphan_valid", rec_valid, 0);
            checkOutput("orphan_err", err, 2'b10);
         end
         if (cyc == 4) checkOutput("bypass_data", rec_data, expRec(3, 3));
         if (cyc == 10) checkOutput("after_orphan_data", rec_data, expRec(6, 9));
      end
      checkOutput("orphan_sticky", err, 2'b10);
      doReset();
      checkOutput("orphan_cleared", err, 0);

      // Backpressure: 10 completions into an 8-deep record FIFO.
      while (cyc < 22)
         applyStimulus(cyc >= 2 && cyc <= 20 && cyc % 2 == 0,
                       cyc >= 3 && cyc <= 21 && cyc % 2 == 1, 0);
      checkOutput("bp_drop", drop_cnt, 2);
      checkOutput("bp_head", rec_data, expRec(2, 3));
      applyStimulus(1, 0, 0);
      applyStimulus(0, 1, 1);
      checkOutput("bp_full_pop_nodrop", drop_cnt, 2);
      for (int k = 2; k <= 8; k++) begin
         checkOutput($sformatf("bp_rec_%0d", k), rec_data, expRec(2*k, 2*k + 1));
         applyStimulus(0, 0, 1);
      end
      checkOutput("bp_rec_last", rec_data, expRec(22, 23));
      applyStimulus(0, 0, 1);
      checkOutput("bp_empty", rec_valid, 0);
      checkOutput("bp_err", err, 0);

      // Timestamp wrap on the 4-bit instance: start 14, done 19 mod 16 = 3.
      doReset();
      while (cyc < 20) applyStimulus(cyc == 14, cyc == 19, 1);
      checkOutput("wrap_valid", wrapValid, 1);
      checkOutput("wrap_data", wrapData, {8'hA5, 4'hE, 4'h3, 4'h5});
      checkOutput("wrap_wide_data", rec_data, expRec(14, 19));

      // Flush with three queued records and rec_ready toggling.
      doReset();
      while (cyc < 7) applyStimulus(cyc == 1 || cyc == 3 || cyc == 5,
                                    cyc == 2 || cyc == 4 || cyc == 6, 0);
      finish = 1'b1;
      applyStimulus(1, 0, 0);
      finish = 1'b0;
      checkOutput("flush_not_done", finish_done, 0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, k == 0, 0);
         checkOutput($sformatf("flush_rec_%0d", k), rec_data, expRec(2*k + 1, 2*k + 2));
         applyStimulus(0, 0, 1);
      end
      checkOutput("flush_empty", rec_valid, 0);
      checkOutput("flush_done_not_yet", finish_done, 0);
      checkOutput("flush_events_ignored", err, 0);
      applyStimulus(0, 0, 0);
      checkOutput("flush_done_rise", finish_done, 1);
      applyStimulus(0, 0, 0);
      checkOutput("flush_done_held", finish_done, 1);

      // Reset in the middle of a flush.
      doReset();
      while (cyc < 4) applyStimulus(cyc == 2, cyc == 1 || cyc == 3, 0);
      finish = 1'b1;
      applyStimulus(0, 0, 0);
      finish = 1'b0;
      checkOutput("midflush_pre_err", err, 2'b10);
      checkOutput("midflush_pre_valid", rec_valid, 1);
      reset = 1'b1;
      applyStimulus(0, 0, 0);
      reset = 1'b0;
      checkOutput("midflush_valid", rec_valid, 0);
      checkOutput("midflush_data", rec_data, 0);
      checkOutput("midflush_err", err, 0);
      checkOutput("midflush_drop", drop_cnt, 0);
      checkOutput("midflush_finish_done", finish_done, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
